// File: rtl/dbus_arbiter_pkg.sv
// Shared dbus payload types and arbiter state encoding.
package dbus_arbiter_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned STRB_W = 8;
   localparam int unsigned SIZE_W = 3;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [SIZE_W-1:0] size;
      logic [STRB_W-1:0] strobe;
      logic [DATA_W-1:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic              addr_ok;
      logic              data_ok;
      logic [DATA_W-1:0] data;
   } dbus_resp_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational priority picker: first valid requester at or after start, wrapping at NREQ-1 -> 0.
module arb_pick #(
   parameter int unsigned NREQ  = 2,
   parameter int unsigned IDX_W = 1
) (
   input  logic [NREQ-1:0]  valid,
   input  logic [IDX_W-1:0] start,
   output logic             any,
   output logic [IDX_W-1:0] idx
);

   // Walk from the farthest candidate back to start so the nearest valid one is written last.
   always_comb begin
      int j;
      j   = 0;
      any = |valid;
      idx = '0;
      for (int k = int'(NREQ) - 1; k >= 0; k--) begin
         j = int'(start) + k;
         if (j >= int'(NREQ)) begin
            j = j - int'(NREQ);
         end
         if (valid[IDX_W'(j)]) begin
            idx = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/dbus_arbiter.sv
// Shares one downstream dbus port among NREQ requesters, one latched transaction at a time.
// Define DBUS_ARB_ROUND_ROBIN_EN for rotating priority; otherwise lowest index wins.
module dbus_arbiter
   import dbus_arbiter_pkg::*;
#(
   parameter int unsigned  NREQ  = 2,
   localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  dbus_req_t        ireq  [NREQ],
   output dbus_resp_t       iresp [NREQ],
   output dbus_req_t        oreq,
   input  dbus_resp_t       oresp,
   output logic             busy,
   output logic [IDX_W-1:0] owner
);

   arb_state_t       state;
   dbus_req_t        req_q;
   logic [NREQ-1:0]  req_valid;
   logic             pick_any;
   logic [IDX_W-1:0] pick_idx;
   logic [IDX_W-1:0] pick_start;

`ifdef DBUS_ARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0] ptr;
   assign pick_start = ptr;
`else
   assign pick_start = '0;
`endif

   always_comb begin
      for (int i = 0; i < int'(NREQ); i++) begin
         req_valid[i] = ireq[i].valid;
      end
   end

   arb_pick #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .valid (req_valid),
      .start (pick_start),
      .any   (pick_any),
      .idx   (pick_idx)
   );

   // Grant in IDLE, hold the latched copy in BUSY until data_ok.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         owner <= '0;
         req_q <= '0;
`ifdef DBUS_ARB_ROUND_ROBIN_EN
         ptr   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  state       <= BUSY;
                  owner       <= pick_idx;
                  req_q       <= ireq[pick_idx];
                  req_q.valid <= 1'b1;
`ifdef DBUS_ARB_ROUND_ROBIN_EN
                  ptr <= (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + IDX_W'(1);
`endif
               end
            end
            BUSY: begin
               if (oresp.data_ok) begin
                  state <= IDLE;
                  req_q <= '0;
               end
            end
            default: begin
               state <= IDLE;
               req_q <= '0;
            end
         endcase
      end
   end

   assign oreq = req_q;
   assign busy = (state == BUSY);

   // Handshakes reach only the owner, and only while a transaction is in flight.
   always_comb begin
      for (int i = 0; i < int'(NREQ); i++) begin
         iresp[i].data    = oresp.data;
         iresp[i].addr_ok = busy && (owner == IDX_W'(i)) && oresp.addr_ok;
         iresp[i].data_ok = busy && (owner == IDX_W'(i)) && oresp.data_ok;
      end
   end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Self-checking bench for dbus_arbiter: directed tables and sequences plus random traffic vs. a transaction model.
module tb_dbus_arbiter;
   import dbus_arbiter_pkg::*;

   localparam int NREQ = 2;

   logic       clk = 1'b0;
   logic       reset;
   dbus_req_t  ireq  [NREQ];
   dbus_resp_t iresp [NREQ];
   dbus_req_t  oreq;
   dbus_resp_t oresp;
   logic       busy;
   logic [0:0] owner;

   int errors = 0;
   int checks = 0;

   // Transaction-level reference: who holds the port and what was captured at grant.
   bit        m_busy;
   int        m_owner;
   int        m_ptr;
   dbus_req_t m_req;

   dbus_arbiter #(.NREQ(NREQ)) dut (
      .clk   (clk),
      .reset (reset),
      .ireq  (ireq),
      .iresp (iresp),
      .oreq  (oreq),
      .oresp (oresp),
      .busy  (busy),
      .owner (owner)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // Winner = valid requester with the smallest rotational distance from the start pointer.
   function automatic int model_pick();
      int start;
      int best;
      int bestd;
      start = 0;
`ifdef DBUS_ARB_ROUND_ROBIN_EN
      start = m_ptr;
`endif
      best  = -1;
      bestd = NREQ;
      for (int i = 0; i < NREQ; i++) begin
         if (ireq[i].valid && ((i - start + NREQ) % NREQ) < bestd) begin
            bestd = (i - start + NREQ) % NREQ;
            best  = i;
         end
      end
      return best;
   endfunction

   task automatic model_cycle();
      int w;
      chk("busy", 128'(busy), 128'(m_busy));
      chk("owner", 128'(owner), 128'(m_owner));
      chk("oreq_valid", 128'(oreq.valid), 128'(m_busy));
      if (m_busy) chk("oreq", 128'(oreq), 128'(m_req));
      for (int i = 0; i < NREQ; i++) begin
         chk($sformatf("addr_ok%0d", i), 128'(iresp[i].addr_ok),
             128'(m_busy && m_owner == i && oresp.addr_ok));
         chk($sformatf("data_ok%0d", i), 128'(iresp[i].data_ok),
             128'(m_busy && m_owner == i && oresp.data_ok));
         chk($sformatf("rdata%0d", i), 128'(iresp[i].data), 128'(oresp.data));
      end
      if (reset) begin
         m_busy  = 1'b0;
         m_owner = 0;
         m_ptr   = 0;
      end else if (!m_busy) begin
         w = model_pick();
         if (w >= 0) begin
            m_busy      = 1'b1;
            m_owner     = w;
            m_req       = ireq[w];
            m_req.valid = 1'b1;
            m_ptr       = (w + 1) % NREQ;
         end
      end else if (oresp.data_ok) begin
         m_busy = 1'b0;
      end
   endtask

   task automatic step();
      #1;
      model_cycle();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < NREQ; i++) ireq[i] = '0;
      oresp = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   typedef struct {
      logic        v0;
      logic        v1;
      logic        dok;
      logic [63:0] rdata;
      logic        exp_busy;
      logic        exp_owner;
      logic        exp_ok0;
      logic        exp_ok1;
   } vec_t;

   initial begin
      vec_t tbl[7];
      int   cnt0;
      int   cnt1;
      int   grants[$];
      logic prev_busy;
      int   exp_seq[4];

      tbl = '{
         '{1'b1, 1'b1, 1'b0, 64'h0,                  1'b0, 1'b0, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b0, 64'h0,                  1'b1, 1'b0, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b1, 64'h1122334455667788,   1'b1, 1'b0, 1'b1, 1'b0},
         '{1'b0, 1'b1, 1'b0, 64'h0,                  1'b0, 1'b0, 1'b0, 1'b0},
         '{1'b0, 1'b1, 1'b1, 64'h0000000000000013,   1'b1, 1'b1, 1'b0, 1'b1},
         '{1'b0, 1'b0, 1'b1, 64'hdeadbeefdeadbeef,   1'b0, 1'b1, 1'b0, 1'b0},
         '{1'b0, 1'b0, 1'b0, 64'h0,                  1'b0, 1'b1, 1'b0, 1'b0}
      };

      clear_inputs();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      m_busy  = 1'b0;
      m_owner = 0;
      m_ptr   = 0;
      m_req   = '0;
      #1;
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_owner", 128'(owner), 128'(0));
      chk("rst_oreq_valid", 128'(oreq.valid), 128'(0));
      chk("rst_oreq_strobe", 128'(oreq.strobe), 128'(0));
      chk("rst_data_ok0", 128'(iresp[0].data_ok), 128'(0));
      chk("rst_addr_ok1", 128'(iresp[1].addr_ok), 128'(0));
      reset = 1'b0;
      @(negedge clk);

      // Single store from port 0, downstream answers on the third busy cycle.
      do_reset();
      cnt0 = 0;
      cnt1 = 0;
      for (int c = 0; c < 5; c++) begin
         ireq[0].valid  = (c < 4);
         ireq[0].addr   = 32'h80000010;
         ireq[0].size   = 3'd3;
         ireq[0].strobe = 8'hff;
         ireq[0].data   = 64'h1122334455667788;
         oresp.data_ok  = (c == 3);
         #1;
         if (c >= 1 && c <= 3) begin
            chk("t1_oreq_addr", 128'(oreq.addr), 128'(32'h80000010));
            chk("t1_oreq_data", 128'(oreq.data), 128'(64'h1122334455667788));
            chk("t1_oreq_strobe", 128'(oreq.strobe), 128'(8'hff));
         end
         cnt0 += int'(iresp[0].data_ok);
         cnt1 += int'(iresp[1].data_ok);
         #0;
         model_cycle();
         @(negedge clk);
      end
      chk("t1_ok0_pulses", 128'(cnt0), 128'(1));
      chk("t1_ok1_pulses", 128'(cnt1), 128'(0));

      // Table: both requesters at once, then dead cycle, then port 1; data_ok in IDLE ignored.
      do_reset();
      for (int s = 0; s < 7; s++) begin
         ireq[0].valid = tbl[s].v0;
         ireq[0].addr  = 32'h80000100;
         ireq[1].valid = tbl[s].v1;
         ireq[1].addr  = 32'hbfc00000;
         oresp.data_ok = tbl[s].dok;
         oresp.data    = tbl[s].rdata;
         #1;
         chk($sformatf("tbl%0d_busy", s), 128'(busy), 128'(tbl[s].exp_busy));
         chk($sformatf("tbl%0d_owner", s), 128'(owner), 128'(tbl[s].exp_owner));
         chk($sformatf("tbl%0d_ok0", s), 128'(iresp[0].data_ok), 128'(tbl[s].exp_ok0));
         chk($sformatf("tbl%0d_ok1", s), 128'(iresp[1].data_ok), 128'(tbl[s].exp_ok1));
         if (tbl[s].exp_ok1) chk($sformatf("tbl%0d_rdata1", s), 128'(iresp[1].data), 128'(tbl[s].rdata));
         model_cycle();
         @(negedge clk);
      end

      // Continuous contention: grant order depends on the priority mode.
      do_reset();
      grants.delete();
      prev_busy = 1'b0;
      ireq[0].valid = 1'b1;
      ireq[1].valid = 1'b1;
      oresp.data_ok = 1'b1;
      for (int c = 0; c < 9; c++) begin
         #1;
         if (busy && !prev_busy) grants.push_back(int'(owner));
         prev_busy = busy;
         model_cycle();
         @(negedge clk);
      end
`ifdef DBUS_ARB_ROUND_ROBIN_EN
      exp_seq = '{0, 1, 0, 1};
`else
      exp_seq = '{0, 0, 0, 0};
`endif
      chk("t3_grant_count", 128'(grants.size() >= 4), 128'(1));
      if (grants.size() >= 4) begin
         for (int g = 0; g < 4; g++) chk($sformatf("t3_grant%0d", g), 128'(grants[g]), 128'(exp_seq[g]));
      end

      // Port 1 changes its address after the grant; the latched copy must stay on oreq.
      do_reset();
      for (int c = 0; c < 4; c++) begin
         ireq[1].valid = 1'b1;
         ireq[1].addr  = (c == 0) ? 32'h00001000 : 32'h00002000;
         oresp.data_ok = (c == 3);
         #1;
         if (c >= 1) chk($sformatf("t4_addr%0d", c), 128'(oreq.addr), 128'(32'h00001000));
         model_cycle();
         @(negedge clk);
      end

      // Reset mid-transaction, then a late data_ok that nobody may see.
      do_reset();
      ireq[0].valid = 1'b1;
      ireq[0].addr  = 32'h80000020;
      step();
      #1;
      chk("t5_busy_before", 128'(busy), 128'(1));
      #0;
      reset = 1'b1;
      model_cycle();
      @(negedge clk);
      reset = 1'b0;
      ireq[0].valid = 1'b0;
      oresp.data_ok = 1'b1;
      #1;
      chk("t5_busy_after", 128'(busy), 128'(0));
      chk("t5_oreq_valid", 128'(oreq.valid), 128'(0));
      chk("t5_late_ok0", 128'(iresp[0].data_ok), 128'(0));
      chk("t5_late_ok1", 128'(iresp[1].data_ok), 128'(0));
      model_cycle();
      @(negedge clk);

      // Random traffic against the model, including occasional resets.
      do_reset();
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            ireq[i].valid  = ($urandom_range(0, 2) != 0);
            ireq[i].addr   = $urandom;
            ireq[i].size   = 3'($urandom);
            ireq[i].strobe = 8'($urandom);
            ireq[i].data   = {$urandom, $urandom};
         end
         oresp.addr_ok = 1'($urandom);
         oresp.data_ok = ($urandom_range(0, 2) == 0);
         oresp.data    = {$urandom, $urandom};
         reset         = ($urandom_range(0, 49) == 0);
         step();
      end
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
